// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes ALU results through and runs one
// outstanding req/ack data-memory transaction for LD/ST instructions.
module mem_access (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        valid_in,
    input  logic [15:0] ir_in,
    input  logic [15:0] alu_in,
    input  logic [15:0] st_data,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        valid_q,
    output logic [15:0] ir_q,
    output logic [15:0] alu_q,
    output logic [15:0] ld_q
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state;

    logic is_ld;
    logic is_st;
    logic accept;
    logic busy_ld;

    assign is_ld = (ir_in[15:14] == 2'b00) && (ir_in[7:0] == 8'h01);
    assign is_st = (ir_in[15:14] == 2'b00) && (ir_in[7:0] == 8'h02);

    // ir_q holds the in-flight instruction for the whole BUSY period
    assign busy_ld = (ir_q[15:14] == 2'b00) && (ir_q[7:0] == 8'h01);

    assign stall  = (state == BUSY);
    assign accept = valid_in && !stall;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            valid_q   <= 1'b0;
            ir_q      <= '0;
            alu_q     <= '0;
            ld_q      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (accept) begin
                        ir_q  <= ir_in;
                        alu_q <= alu_in;
                        if (is_ld || is_st) begin
                            mem_req   <= 1'b1;
                            mem_addr  <= alu_in;
                            mem_we    <= is_st;
                            mem_wdata <= is_st ? st_data : 16'h0000;
                            state     <= BUSY;
                        end else begin
                            valid_q <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        valid_q <= 1'b1;
                        if (busy_ld) begin
                            ld_q <= mem_rdata;
                        end
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access against a per-instruction reference model.
module tb_mem_access;

    logic        CLK;
    logic        RSTN;
    logic        valid_in;
    logic [15:0] ir_in;
    logic [15:0] alu_in;
    logic [15:0] st_data;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        valid_q;
    logic [15:0] ir_q;
    logic [15:0] alu_q;
    logic [15:0] ld_q;

    int n_tests = 0;
    int n_fail  = 0;

    // reference view of the architectural output registers
    logic [15:0] m_ir;
    logic [15:0] m_alu;
    logic [15:0] m_ld;

    mem_access dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .valid_in  (valid_in),
        .ir_in     (ir_in),
        .alu_in    (alu_in),
        .st_data   (st_data),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .valid_q   (valid_q),
        .ir_q      (ir_q),
        .alu_q     (alu_q),
        .ld_q      (ld_q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic bit f_ld(input logic [15:0] ir);
        return ir[15:14] == 2'b00 && ir[7:0] == 8'h01;
    endfunction

    function automatic bit f_st(input logic [15:0] ir);
        return ir[15:14] == 2'b00 && ir[7:0] == 8'h02;
    endfunction

    task automatic chk_regs(input string tag, input logic v);
        chk({tag, ".valid_q"}, {15'b0, valid_q}, {15'b0, v});
        chk({tag, ".ir_q"}, ir_q, m_ir);
        chk({tag, ".alu_q"}, alu_q, m_alu);
        chk({tag, ".ld_q"}, ld_q, m_ld);
    endtask

    // Present one instruction; memory acks on request cycle lat.
    task automatic run_instr(input logic [15:0] ir, input logic [15:0] alu,
                             input logic [15:0] sd, input int lat,
                             input logic [15:0] rd);
        bit ld;
        bit st;
        ld = f_ld(ir);
        st = f_st(ir);
        valid_in = 1'b1;
        ir_in    = ir;
        alu_in   = alu;
        st_data  = sd;
        mem_ack  = 1'b0;
        @(posedge CLK);
        #1;
        m_ir  = ir;
        m_alu = alu;
        if (ld || st) begin
            for (int c = 1; c <= lat; c++) begin
                chk("busy.stall", {15'b0, stall}, 16'd1);
                chk("busy.mem_req", {15'b0, mem_req}, 16'd1);
                chk("busy.mem_we", {15'b0, mem_we}, {15'b0, st});
                chk("busy.mem_addr", mem_addr, alu);
                chk("busy.mem_wdata", mem_wdata, st ? sd : 16'h0000);
                chk_regs("busy", 1'b0);
                // upstream junk must be ignored while stalled
                valid_in  = 1'($urandom_range(0, 1));
                ir_in     = 16'($urandom);
                alu_in    = 16'($urandom);
                st_data   = 16'($urandom);
                mem_ack   = (c == lat);
                mem_rdata = (c == lat) ? rd : 16'($urandom);
                @(posedge CLK);
                #1;
                mem_ack = 1'b0;
            end
            if (ld) m_ld = rd;
            chk("done.mem_req", {15'b0, mem_req}, 16'd0);
            chk("done.mem_we", {15'b0, mem_we}, 16'd0);
            chk("done.stall", {15'b0, stall}, 16'd0);
            chk_regs("done", 1'b1);
        end else begin
            chk("alu.mem_req", {15'b0, mem_req}, 16'd0);
            chk("alu.stall", {15'b0, stall}, 16'd0);
            chk_regs("alu", 1'b1);
        end
        valid_in = 1'b0;
    endtask

    // Idle cycles, optionally with spurious acks that must be ignored.
    task automatic run_idle(input int n, input bit spur);
        for (int i = 0; i < n; i++) begin
            valid_in  = 1'b0;
            ir_in     = 16'($urandom);
            mem_ack   = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = 16'($urandom);
            @(posedge CLK);
            #1;
            mem_ack = 1'b0;
            chk("idle.stall", {15'b0, stall}, 16'd0);
            chk("idle.mem_req", {15'b0, mem_req}, 16'd0);
            chk_regs("idle", 1'b0);
        end
    endtask

    function automatic logic [15:0] rand_ir(input int kind);
        logic [15:0] r;
        r = 16'($urandom);
        if (kind == 0) return {2'b00, r[13:8], 8'h01};
        if (kind == 1) return {2'b00, r[13:8], 8'h02};
        while (f_ld(r) || f_st(r)) r = 16'($urandom);
        return r;
    endfunction

    initial begin
        RSTN      = 1'b0;
        valid_in  = 1'b1;
        ir_in     = 16'h0001;
        alu_in    = 16'h1111;
        st_data   = 16'h2222;
        mem_ack   = 1'b1;
        mem_rdata = 16'h3333;
        m_ir  = '0;
        m_alu = '0;
        m_ld  = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst.stall", {15'b0, stall}, 16'd0);
        chk("rst.mem_req", {15'b0, mem_req}, 16'd0);
        chk("rst.mem_we", {15'b0, mem_we}, 16'd0);
        chk("rst.mem_addr", mem_addr, 16'd0);
        chk("rst.mem_wdata", mem_wdata, 16'd0);
        chk_regs("rst", 1'b0);
        valid_in = 1'b0;
        mem_ack  = 1'b0;
        RSTN     = 1'b1;
        run_idle(2, 1'b0);
        chk("post_rst.mem_addr", mem_addr, 16'd0);

        for (int i = 0; i < 3; i++) run_instr(16'h4003, 16'h1234, 0, 1, 0);
        run_idle(1, 1'b0);

        run_instr(16'h0001, 16'h0020, 16'h0, 3, 16'hBEEF);
        run_idle(1, 1'b0);
        run_instr(16'h0002, 16'h0040, 16'h5A5A, 1, 16'h7777);
        run_idle(1, 1'b0);

        run_instr(16'h0001, 16'h0060, 16'h0, 2, 16'hC0DE);
        run_instr(16'h8005, 16'h0abc, 16'h0, 1, 16'h0);
        run_idle(4, 1'b1);

        // reset while a load is outstanding
        valid_in = 1'b1;
        ir_in    = 16'h0001;
        alu_in   = 16'h0080;
        @(posedge CLK);
        #1;
        valid_in = 1'b0;
        @(posedge CLK);
        #2;
        chk("mid.mem_req_pre", {15'b0, mem_req}, 16'd1);
        RSTN = 1'b0;
        #1;
        m_ir  = '0;
        m_alu = '0;
        m_ld  = '0;
        chk("mid.mem_req", {15'b0, mem_req}, 16'd0);
        chk("mid.stall", {15'b0, stall}, 16'd0);
        chk("mid.mem_addr", mem_addr, 16'd0);
        chk_regs("mid", 1'b0);
        mem_ack = 1'b1;
        @(posedge CLK);
        #1;
        mem_ack = 1'b0;
        RSTN    = 1'b1;
        run_idle(1, 1'b0);
        run_instr(16'h4003, 16'h1234, 0, 1, 0);

        for (int i = 0; i < 80; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            run_instr(rand_ir(kind), 16'($urandom), 16'($urandom),
                      $urandom_range(1, 4), 16'($urandom));
            if ($urandom_range(0, 3) == 0) run_idle($urandom_range(1, 2), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
